// File: rtl/jtframe_mainbus.sv
// Main-CPU bus controller for Konami-style 6809 boards: address decode, banked ROM
// window with wait states, control registers, edge-latched IRQ controller, watchdog.
module jtframe_mainbus #(
   parameter int BANK_W   = 4,
   parameter int BANK_OFS = 2,
   parameter int ROM_AW   = 18,
   parameter int IRQ_N    = 2,
   parameter int WDOG_W   = 20
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_cen,
   input  logic [15:0]       A,
   input  logic              rnw,
   input  logic [7:0]        cpu_dout,
   output logic [7:0]        cpu_din,
   output logic              rom_cs,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic              rom_ok,
   output logic              waitn,
   output logic              ram_cs,
   output logic              pal_cs,
   output logic              gfx_cs,
   output logic              io_cs,
   output logic [2:0]        io_sel,
   input  logic [7:0]        ram_dout,
   input  logic [7:0]        pal_dout,
   input  logic [7:0]        gfx_dout,
   input  logic [7:0]        io_din,
   output logic [BANK_W-1:0] bank,
   input  logic [IRQ_N-1:0]  irq_trig,
   input  logic              irq_ack,
   input  logic              dip_pause,
   output logic              irq_n,
   output logic [7:0]        snd_latch,
   output logic              snd_irq,
   input  logic              snd_ack,
   output logic              wdog_rst,
   output logic [0:0]        fsm_st
);

   localparam int PW = ROM_AW - 14;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic          rom_rgn, any_cs;
   logic [PW-1:0] page;

   assign rom_rgn = A[15] | (A[15:14] == 2'b01);
   assign rom_cs  = rom_rgn & rnw;
   assign ram_cs  = A[15:11] == 5'b00011;
   assign pal_cs  = A[15:11] == 5'b00010;
   assign gfx_cs  = (A[15:13] == 3'b001) | (A[15:8] == 8'h00);
   assign io_cs   = A[15:11] == 5'b00001;
   assign io_sel  = io_cs ? A[10:8] : 3'd0;
   assign any_cs  = rom_cs | ram_cs | pal_cs | gfx_cs | io_cs;

   // Bank page wraps within the ROM size rather than spilling past it
   assign page     = PW'(bank) + PW'(BANK_OFS);
   assign rom_addr = A[15] ? ROM_AW'(A[14:0]) : {page, A[13:0]};

   assign cpu_din = ({8{rom_cs}} & rom_data) | ({8{ram_cs}} & ram_dout)
                  | ({8{pal_cs}} & pal_dout) | ({8{gfx_cs}} & gfx_dout)
                  | ({8{io_cs }} & io_din  ) | ({8{~any_cs}} & 8'hFF);

   logic wr, wr_bank, wr_en, wdog_clr, wr_slatch, wr_sirq;
   assign wr        = cpu_cen & ~rnw & io_cs;
   assign wr_bank   = wr & (A == 16'h0C00);
   assign wr_en     = wr & (A == 16'h0C01);
   assign wdog_clr  = wr & (A == 16'h0E00);
   assign wr_slatch = wr & (A == 16'h0F00);
   assign wr_sirq   = wr & (A == 16'h0F01);

   logic [IRQ_N-1:0] irq_en, en_next, pend, pend_next, trig_s, trig_l, irq_edge, ack_mask;

   assign en_next   = wr_en ? cpu_dout[IRQ_N-1:0] : irq_en;
   assign irq_edge  = trig_s & ~trig_l & irq_en & {IRQ_N{dip_pause}};
   // Isolates the lowest set pending bit
   assign ack_mask  = {IRQ_N{irq_ack}} & pend & (~pend + IRQ_N'(1));
   assign pend_next = ((pend & ~ack_mask) | irq_edge) & en_next;
   assign irq_n     = ~|pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         bank      <= '0;
         irq_en    <= '0;
         pend      <= '0;
         trig_s    <= '0;
         trig_l    <= '0;
         snd_latch <= 8'd0;
         snd_irq   <= 1'b0;
      end else begin
         trig_s <= irq_trig;
         trig_l <= trig_s;
         irq_en <= en_next;
         pend   <= pend_next;
         if (wr_bank)   bank      <= cpu_dout[BANK_W-1:0];
         if (wr_slatch) snd_latch <= cpu_dout;
         if (wr_sirq)      snd_irq <= 1'b1;
         else if (snd_ack) snd_irq <= 1'b0;
      end
   end

   // Wait-state FSM: a_q holds last clk's address so an acknowledge arriving
   // in the same clk the address moves is treated as stale.
   logic [0:0]  st;
   logic [15:0] last_a, a_q;
   logic        start, done;

   assign start  = ~rst & (st == ST_IDLE) & cpu_cen & rom_cs & ((A != last_a) | ~rom_ok);
   assign done   = (st == ST_WAIT) & rom_ok & (A == a_q);
   assign waitn  = ~(start | (st == ST_WAIT));
   assign fsm_st = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= ST_IDLE;
         last_a <= 16'hFFFF;
         a_q    <= 16'hFFFF;
      end else begin
         a_q <= A;
         case (st)
            ST_IDLE: if (start) st <= ST_WAIT;
            ST_WAIT: if (done) begin
               st     <= ST_IDLE;
               last_a <= A;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   generate
      if (WDOG_W > 0) begin : g_wdog
         logic [WDOG_W-1:0] wdog_cnt;
         always_ff @(posedge clk) begin
            if (rst) begin
               wdog_cnt <= '0;
               wdog_rst <= 1'b0;
            end else begin
               wdog_rst <= 1'b0;
               if (wdog_clr) wdog_cnt <= '0;
               else if (cpu_cen) begin
                  wdog_cnt <= wdog_cnt + WDOG_W'(1);
                  wdog_rst <= &wdog_cnt;
               end
            end
         end
      end else begin : g_nowdog
         assign wdog_rst = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_jtframe_mainbus.sv
// Directed bench for jtframe_mainbus: decode, bank window, IRQs, sound latch,
// wait states and watchdog, checked against a queue of expected values.
module tb_jtframe_mainbus;

   localparam int ROM_AW = 18;

   logic clk = 1'b0, rst = 1'b1, cpu_cen = 1'b0, rnw = 1'b1;
   logic [15:0] A = 16'h0100;
   logic [7:0]  cpu_dout = 8'd0, cpu_din;
   logic rom_cs, rom_ok = 1'b1, waitn, ram_cs, pal_cs, gfx_cs, io_cs;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0] rom_data = 8'h55, ram_dout = 8'h11, pal_dout = 8'h22, gfx_dout = 8'h33, io_din = 8'h44;
   logic [2:0] io_sel;
   logic [3:0] bank;
   logic [1:0] irq_trig = 2'b00;
   logic irq_ack = 1'b0, dip_pause = 1'b1, irq_n, snd_irq, snd_ack = 1'b0, wdog_rst;
   logic [7:0] snd_latch;
   logic [0:0] fsm_st;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   jtframe_mainbus #(.BANK_W(4), .BANK_OFS(2), .ROM_AW(ROM_AW), .IRQ_N(2), .WDOG_W(4)) dut (
      .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .A(A), .rnw(rnw), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
      .rom_ok(rom_ok), .waitn(waitn), .ram_cs(ram_cs), .pal_cs(pal_cs), .gfx_cs(gfx_cs),
      .io_cs(io_cs), .io_sel(io_sel), .ram_dout(ram_dout), .pal_dout(pal_dout),
      .gfx_dout(gfx_dout), .io_din(io_din), .bank(bank), .irq_trig(irq_trig),
      .irq_ack(irq_ack), .dip_pause(dip_pause), .irq_n(irq_n), .snd_latch(snd_latch),
      .snd_irq(snd_irq), .snd_ack(snd_ack), .wdog_rst(wdog_rst), .fsm_st(fsm_st)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      A = a; cpu_dout = d; rnw = 1'b0; cpu_cen = 1'b1;
      cyc();
      cpu_cen = 1'b0; rnw = 1'b1; A = 16'h0100;
   endtask

   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_assert++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %h but no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      push_exp(expv);
      check(tag, obs);
   endtask

   // sel order: {rom, ram, pal, gfx, io}
   task automatic dec(input logic [15:0] a, input logic [4:0] sel, input logic [7:0] din);
      A = a; rnw = 1'b1;
      #1;
      chk($sformatf("sel_%h", a), 32'({rom_cs, ram_cs, pal_cs, gfx_cs, io_cs}), 32'(sel));
      chk($sformatf("din_%h", a), 32'(cpu_din), 32'(din));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int pulses, first, dbl;
      logic prev;

      // reset
      repeat (3) cyc();
      chk("rst_bank",    32'(bank),      32'h0);
      chk("rst_irq_n",   32'(irq_n),     32'h1);
      chk("rst_slatch",  32'(snd_latch), 32'h0);
      chk("rst_sirq",    32'(snd_irq),   32'h0);
      chk("rst_wdog",    32'(wdog_rst),  32'h0);
      chk("rst_waitn",   32'(waitn),     32'h1);
      chk("rst_fsm",     32'(fsm_st),    32'h0);
      rst = 1'b0;
      cyc();

      // decode map
      dec(16'h0050, 5'b00010, 8'h33);
      dec(16'h0100, 5'b00000, 8'hFF);
      dec(16'h07FF, 5'b00000, 8'hFF);
      dec(16'h0900, 5'b00001, 8'h44);
      chk("io_sel_0900", 32'(io_sel), 32'h1);
      dec(16'h0FFF, 5'b00001, 8'h44);
      chk("io_sel_0fff", 32'(io_sel), 32'h7);
      dec(16'h1000, 5'b00100, 8'h22);
      dec(16'h17FF, 5'b00100, 8'h22);
      dec(16'h1800, 5'b01000, 8'h11);
      dec(16'h2000, 5'b00010, 8'h33);
      dec(16'h3FFF, 5'b00010, 8'h33);
      dec(16'h4000, 5'b10000, 8'h55);
      dec(16'hFFFF, 5'b10000, 8'h55);
      A = 16'h8000; rnw = 1'b0; #1;
      chk("rom_cs_write", 32'(rom_cs), 32'h0);
      rnw = 1'b1; A = 16'h0100;

      // bank window
      bus_write(16'h0C00, 8'h05);
      chk("bank", 32'(bank), 32'h5);
      A = 16'h4123; #1;
      chk("rom_addr_bank", 32'(rom_addr), 32'h1C123);
      A = 16'h8010; #1;
      chk("rom_addr_fixed", 32'(rom_addr), 32'h00010);
      A = 16'h0100;

      // IRQ controller
      bus_write(16'h0C01, 8'h03);
      irq_trig[1] = 1'b1;
      cyc();
      chk("irq_lat1", 32'(irq_n), 32'h1);
      cyc();
      chk("irq_lat2", 32'(irq_n), 32'h0);
      irq_trig[0] = 1'b1;
      repeat (2) cyc();
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("irq_ack1", 32'(irq_n), 32'h0);
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("irq_ack2", 32'(irq_n), 32'h1);
      irq_trig = 2'b00;
      repeat (2) cyc();
      dip_pause = 1'b0; irq_trig[0] = 1'b1;
      repeat (3) cyc();
      chk("irq_paused", 32'(irq_n), 32'h1);
      dip_pause = 1'b1; irq_trig = 2'b00;
      repeat (2) cyc();
      irq_trig[0] = 1'b1;
      repeat (2) cyc();
      chk("irq_pend0", 32'(irq_n), 32'h0);
      bus_write(16'h0C01, 8'h00);
      chk("irq_en_clr", 32'(irq_n), 32'h1);
      irq_trig = 2'b00;
      bus_write(16'h0C01, 8'h01);
      repeat (2) cyc();
      irq_trig[1] = 1'b1;
      repeat (3) cyc();
      chk("irq_masked_ch1", 32'(irq_n), 32'h1);
      irq_trig = 2'b00;
      repeat (2) cyc();
      // pend[0] set, then a fresh edge lands in the same clk as the ack
      irq_trig[0] = 1'b1; repeat (2) cyc();
      irq_trig[0] = 1'b0; repeat (2) cyc();
      irq_trig[0] = 1'b1; cyc();
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("irq_set_wins", 32'(irq_n), 32'h0);
      irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
      chk("irq_ack_last", 32'(irq_n), 32'h1);
      irq_trig = 2'b00;

      // sound latch handshake
      bus_write(16'h0F00, 8'h3A);
      chk("snd_latch", 32'(snd_latch), 32'h3A);
      chk("snd_irq_idle", 32'(snd_irq), 32'h0);
      bus_write(16'h0F01, 8'h00);
      repeat (2) cyc();
      chk("snd_irq_held", 32'(snd_irq), 32'h1);
      snd_ack = 1'b1; cyc(); snd_ack = 1'b0;
      chk("snd_irq_ack", 32'(snd_irq), 32'h0);
      snd_ack = 1'b1; bus_write(16'h0F01, 8'h00); snd_ack = 1'b0;
      chk("snd_irq_wr_wins", 32'(snd_irq), 32'h1);

      // wait states: slow ROM
      A = 16'h8010; rnw = 1'b1; cpu_cen = 1'b1; rom_ok = 1'b0; #1;
      chk("wait_fall", 32'(waitn), 32'h0);
      cyc(); cpu_cen = 1'b0;
      chk("wait_fsm", 32'(fsm_st), 32'h1);
      for (int i = 0; i < 5; i++) begin
         push_exp(32'h0);
         check($sformatf("wait_hold%0d", i), 32'(waitn));
         cyc();
      end
      rom_ok = 1'b1; #1;
      chk("wait_ok_same_clk", 32'(waitn), 32'h0);
      cyc();
      chk("wait_release", 32'(waitn), 32'h1);
      // new address with rom_ok already high still waits
      A = 16'h8020; cpu_cen = 1'b1; #1;
      chk("stale_fall", 32'(waitn), 32'h0);
      cyc(); cpu_cen = 1'b0;
      A = 16'h8030;
      cyc();
      chk("stale_ignored", 32'(waitn), 32'h0);
      cyc();
      chk("stale_release", 32'(waitn), 32'h1);
      cpu_cen = 1'b1; #1;
      chk("wait_hit", 32'(waitn), 32'h1);
      cyc(); cpu_cen = 1'b0;
      // reset in the middle of a wait
      A = 16'h8050; rom_ok = 1'b0; cpu_cen = 1'b1;
      cyc(); cpu_cen = 1'b0;
      rst = 1'b1;
      cyc();
      chk("rst_mid_wait", 32'(waitn), 32'h1);
      chk("rst_mid_fsm", 32'(fsm_st), 32'h0);
      rst = 1'b0; rom_ok = 1'b1; A = 16'h0100;

      // watchdog, free-running
      pulses = 0; first = 0; dbl = 0; prev = 1'b0;
      cpu_cen = 1'b1; rnw = 1'b1;
      for (int i = 1; i <= 48; i++) begin
         cyc();
         if (wdog_rst) begin
            pulses++;
            if (first == 0) first = i;
            if (prev) dbl++;
         end
         prev = wdog_rst;
      end
      chk("wdog_pulses", 32'(pulses), 32'd3);
      chk("wdog_first",  32'(first),  32'd16);
      chk("wdog_width",  32'(dbl),    32'd0);
      // watchdog, kicked every 10 cpu_cen
      pulses = 0;
      for (int i = 1; i <= 60; i++) begin
         if (i % 10 == 0) begin A = 16'h0E00; rnw = 1'b0; end
         else begin A = 16'h0100; rnw = 1'b1; end
         cyc();
         if (wdog_rst) pulses++;
      end
      chk("wdog_kicked", 32'(pulses), 32'd0);
      cpu_cen = 1'b0; rnw = 1'b1; A = 16'h0100;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
